// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo
// Moore control unit for the sequence game. It clears and steps the round counter,
// loads the play register, edge-detects the player button and times out a stalled play.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   iniciar    start request (level)
//   jogada     player button (level, edge-detected internally)
//   igual      registered play matches expected value
//   fimC       round counter at its last value
//   zeraC      clear round counter
//   contaC     step round counter
//   zeraR      clear play register
//   registraR  load play register
//   acertou    final: all plays correct
//   errou      final: wrong play
//   timeout    final: no play within TIMEOUT cycles
//   pronto     high in any final state
//   db_estado  current state code
module unidade_controle_jogo #(
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned N       = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StPreparacao = 4'd1,
    StEspera     = 4'd2,
    StRegistra   = 4'd4,
    StComparacao = 4'd5,
    StProximo    = 4'd6,
    StFimAcertou = 4'd10,
    StFimTimeout = 4'd13,
    StFimErrou   = 4'd14
  } estado_t;

  localparam logic [N-1:0] TimerMax = N'(TIMEOUT - 1);

  estado_t      estado_q, estado_d;
  logic [N-1:0] timer_q, timer_d;
  logic         jogada_d;
  logic         jogada_pulse;
  // {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto}
  logic [7:0]   saidas_q, saidas_d;

  assign jogada_pulse = jogada & ~jogada_d;

  // Next state and timer. The timer only runs in espera and is zero on every exit,
  // so a fresh espera visit always starts counting from 0.
  always_comb begin
    estado_d = estado_q;
    timer_d  = '0;
    case (estado_q)
      StInicial: begin
        if (iniciar) estado_d = StPreparacao;
      end
      StPreparacao: estado_d = StEspera;
      StEspera: begin
        // A press beats the terminal count in the same cycle.
        if (jogada_pulse) begin
          estado_d = StRegistra;
        end else if (timer_q == TimerMax) begin
          estado_d = StFimTimeout;
        end else begin
          timer_d = timer_q + N'(1);
        end
      end
      StRegistra: estado_d = StComparacao;
      StComparacao: begin
        if (!igual) begin
          estado_d = StFimErrou;
        end else if (fimC) begin
          estado_d = StFimAcertou;
        end else begin
          estado_d = StProximo;
        end
      end
      StProximo: estado_d = StEspera;
      StFimAcertou, StFimErrou, StFimTimeout: begin
        if (iniciar) estado_d = StPreparacao;
      end
      default: estado_d = StInicial;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the
  // state register while staying glitch-free.
  always_comb begin
    saidas_d = 8'b0;
    case (estado_d)
      StPreparacao: saidas_d = 8'b1010_0000;
      StRegistra:   saidas_d = 8'b0001_0000;
      StProximo:    saidas_d = 8'b0100_0000;
      StFimAcertou: saidas_d = 8'b0000_1001;
      StFimErrou:   saidas_d = 8'b0000_0101;
      StFimTimeout: saidas_d = 8'b0000_0011;
      default:      saidas_d = 8'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= StInicial;
      timer_q  <= '0;
      jogada_d <= 1'b0;
      saidas_q <= 8'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      jogada_d <= jogada;
      saidas_q <= saidas_d;
    end
  end

  assign {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto} = saidas_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

  localparam int unsigned TimeoutCyc = 8;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimC;
  logic zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  unidade_controle_jogo #(
    .TIMEOUT(TimeoutCyc),
    .N      (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .jogada   (jogada),
    .igual    (igual),
    .fimC     (fimC),
    .zeraC    (zeraC),
    .contaC   (contaC),
    .zeraR    (zeraR),
    .registraR(registraR),
    .acertou  (acertou),
    .errou    (errou),
    .timeout  (timeout),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, ini, jog, igu, fim;
    logic [3:0] est;  // state expected after the edge
  } vec_t;

  typedef struct {
    logic [11:0] v;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function void add(input logic r, i, j, g, f, input logic [3:0] e);
    vec_t t;
    t.rst = r; t.ini = i; t.jog = j; t.igu = g; t.fim = f; t.est = e;
    vecs.push_back(t);
  endfunction

  // Expected {db_estado, zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto}
  function automatic logic [11:0] modelo(input logic [3:0] e);
    logic [7:0] o;
    case (e)
      4'd1:    o = 8'b1010_0000;
      4'd4:    o = 8'b0001_0000;
      4'd6:    o = 8'b0100_0000;
      4'd10:   o = 8'b0000_1001;
      4'd14:   o = 8'b0000_0101;
      4'd13:   o = 8'b0000_0011;
      default: o = 8'b0;
    endcase
    return {e, o};
  endfunction

  // Monitor: compares one scoreboard entry per edge, 1 time unit after it.
  always @(posedge clock) begin
    exp_t e;
    logic [11:0] got;
    #1;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      got = {db_estado, zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto};
      total++;
      if (got === e.v) passed++;
      else $display("FAIL vec%0d: got est=%0d outs=%b, required est=%0d outs=%b",
                    e.idx, got[11:8], got[7:0], e.v[11:8], e.v[7:0]);
    end
  end

  task automatic play_ok(input logic last);
    add(0, 0, 1, 0, 0, 4'd4);
    add(0, 0, 0, 0, 0, 4'd5);
    add(0, 0, 0, 1, last, last ? 4'd10 : 4'd6);
    add(0, 0, 0, 0, 0, last ? 4'd10 : 4'd2);
  endtask

  initial begin
    exp_t x;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;

    // Reset, start, timeout after exactly TimeoutCyc edges in espera.
    add(1, 0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 0, 4'd0);
    add(0, 0, 0, 0, 0, 4'd0);
    add(0, 1, 0, 0, 0, 4'd1);
    add(0, 0, 0, 0, 0, 4'd2);
    for (int i = 0; i < TimeoutCyc - 1; i++) add(0, 0, 0, 0, 0, 4'd2);
    add(0, 0, 0, 0, 0, 4'd13);
    add(0, 0, 0, 0, 0, 4'd13);

    // Four correct plays, fimC only on the last comparison.
    add(0, 1, 0, 0, 0, 4'd1);
    add(0, 0, 0, 0, 0, 4'd2);
    for (int i = 0; i < 3; i++) play_ok(1'b0);
    play_ok(1'b1);

    // Wrong second play.
    add(0, 1, 0, 0, 0, 4'd1);
    add(0, 0, 0, 0, 0, 4'd2);
    play_ok(1'b0);
    add(0, 0, 1, 0, 0, 4'd4);
    add(0, 0, 0, 0, 0, 4'd5);
    add(0, 0, 0, 0, 0, 4'd14);
    add(0, 0, 0, 0, 0, 4'd14);

    // Button held from preparacao into espera: no registra until released and re-pressed.
    add(0, 1, 1, 0, 0, 4'd1);
    add(0, 0, 1, 0, 0, 4'd2);
    add(0, 0, 1, 0, 0, 4'd2);
    add(0, 0, 1, 0, 0, 4'd2);
    add(0, 0, 0, 0, 0, 4'd2);
    add(0, 0, 1, 0, 0, 4'd4);
    add(0, 0, 0, 0, 0, 4'd5);
    add(0, 0, 0, 0, 0, 4'd14);

    // Press exactly on the terminal count: registra wins.
    add(0, 1, 0, 0, 0, 4'd1);
    add(0, 0, 0, 0, 0, 4'd2);
    for (int i = 0; i < TimeoutCyc - 1; i++) add(0, 0, 0, 0, 0, 4'd2);
    play_ok(1'b0);

    // Reset mid-espera, reset dominating iniciar/jogada.
    add(0, 0, 0, 0, 0, 4'd2);
    add(1, 0, 0, 0, 0, 4'd0);
    add(1, 1, 1, 0, 0, 4'd0);
    add(0, 0, 0, 0, 0, 4'd0);

    // Timer starts from zero again after reset.
    add(0, 1, 0, 0, 0, 4'd1);
    add(0, 0, 0, 0, 0, 4'd2);
    for (int i = 0; i < TimeoutCyc - 1; i++) add(0, 0, 0, 0, 0, 4'd2);
    add(0, 0, 0, 0, 0, 4'd13);

    foreach (vecs[k]) begin
      reset   = vecs[k].rst;
      iniciar = vecs[k].ini;
      jogada  = vecs[k].jog;
      igual   = vecs[k].igu;
      fimC    = vecs[k].fim;
      x.v     = modelo(vecs[k].est);
      x.idx   = k;
      sb.push_back(x);
      @(negedge clock);
    end
    iniciar = 1'b0; jogada = 1'b0;
    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
# unidade_controle_jogo

Moore-style control unit for the sequence-game datapath, sitting directly upstream of the round counter (`contador_m`). It clears the counter, steps it after each correct play, and consumes its end-of-count flag (`fimC`). It also drives the play register load, edge-detects the player's button input, and enforces a per-play timeout with an internal timer. Final status is reported as acertou, errou or timeout.

## Interface
- TIMEOUT, 5000: maximum cycles spent waiting for one play (≥2).
- N, 13: internal timer width; 2^N ≥ TIMEOUT.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start request, level, sampled each edge.
- jogada  in  1  player button, level; the internal rising-edge detector turns it into a one-cycle pulse.
- igual  in  1  comparator result: the registered play matches the expected value.
- fimC  in  1  counter end-of-count flag (counter Q == M-1).
- zeraC  out  1  synchronous clear to the counter (`zera_s`).
- contaC  out  1  counter enable (`conta`).
- zeraR  out  1  synchronous clear to the play register.
- registraR  out  1  load enable to the play register.
- acertou, errou, timeout  out  1 each  final-result flags.
- pronto  out  1  high in any final state.
- db_estado  out  4  current state code, for debug display.

## Operation
- State register, a timer (N bits) and a delayed copy of jogada (`jogada_d`). `jogada_pulse = jogada & ~jogada_d`.
- Outputs are decoded from the state only (Moore). An output is 0 in every state where it is not listed.
- States, with db_estado code, outputs and transitions:
  - inicial (0): no outputs. iniciar=1 → preparacao.
  - preparacao (1): zeraC=1, zeraR=1. Unconditionally → espera.
  - espera (2): timer increments each cycle. jogada_pulse → registra. Otherwise, timer==TIMEOUT-1 → fim_timeout. Otherwise stay.
  - registra (4): registraR=1. → comparacao.
  - comparacao (5): igual=0 → fim_errou. igual=1 and fimC=1 → fim_acertou. igual=1 and fimC=0 → proximo.
  - proximo (6): contaC=1. → espera.
  - fim_acertou (10): acertou=1, pronto=1. iniciar=1 → preparacao.
  - fim_errou (14): errou=1, pronto=1. iniciar=1 → preparacao.
  - fim_timeout (13): timeout=1, pronto=1. iniciar=1 → preparacao.
- Timer:
  - Holds 0 in every state other than espera.
  - Counts 0..TIMEOUT-1 within espera, so one espera visit lasts at most TIMEOUT cycles.
  - Cleared on every exit from espera.
- Priority in espera: jogada_pulse wins over the timeout terminal count in the same cycle.
- iniciar is ignored in preparacao, espera, registra, comparacao and proximo.
- jogada_pulse is ignored (not latched) outside espera.
- A button already held high on entry to espera produces no pulse. It must be released and pressed again.
- Unused state codes → inicial on the next edge.

## Timing
- Reset (synchronous): at the first edge with reset=1:
  - state ← inicial, timer ← 0, jogada_d ← 0.
  - All outputs read 0 (db_estado=0) from that edge on.
  - Applies from any state, including mid-round.
  - Reset dominates iniciar and jogada.
- The counter's clear and count take effect at the edge ending preparacao or proximo respectively. Therefore fimC is valid in comparacao.
- Play latency: jogada sampled 1 at edge k (sampled 0 at k-1) gives:
  - registra during cycle k..k+1;
  - comparacao during cycle k+1..k+2;
  - the final or proximo state from edge k+2.
- Timeout: entering espera at edge e with no press gives fim_timeout at edge e+TIMEOUT.
- Round with M plays and no waiting: preparacao 1 cycle, then per play at least 3 cycles of espera/registra/comparacao plus 1 cycle of proximo.

## Test plan
- Reset, then iniciar pulse. Required:
  - db_estado 0→1→2;
  - zeraC=zeraR=1 for exactly one cycle;
  - timer at 0.
- TIMEOUT=8, no jogada after entering espera. Required:
  - fim_timeout exactly 8 cycles later;
  - timeout=pronto=1, db_estado=13.
- Four presses with igual=1, fimC=1 only on the 4th comparacao. Required:
  - contaC pulses 3 times, registraR pulses 4 times;
  - ends in fim_acertou (acertou=1, db_estado=10).
- Press with igual=0 on the 2nd play. Required: fim_errou (errou=1, db_estado=14) after one contaC pulse.
- jogada held high through preparacao into espera. Required:
  - no registra occurs;
  - after release and re-press, registra follows the next edge.
- Two simultaneous-event cases:
  - jogada rises exactly when timer==TIMEOUT-1. Required: registra, not fim_timeout.
  - reset asserted during espera. Required: inicial and all outputs 0 at the next edge.
